// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces three buttons, then issues one
// prioritized, fixed-width command pulse followed by a lockout window.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 10,
    parameter int LOCKOUT_CYCLES  = 838400
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_put,
    output logic left,
    output logic right,
    output logic put,
    output logic busy
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MC = PULSE_CYCLES > LOCKOUT_CYCLES ? PULSE_CYCLES : LOCKOUT_CYCLES;
    localparam int CW = $clog2(MC + 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCKOUT_CYCLES == 0 ? 0 : LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT} state_t;

    logic [2:0]    raw, s1, s2, db, ev, cmd, cmd_sel, cmd_n, out_n;
    logic [DW-1:0] dcnt [3];
    logic [CW-1:0] cnt, cnt_n;
    logic          busy_n;
    state_t        state, state_n;

    assign raw = {btn_put, btn_right, btn_left};

    always_ff @(posedge clk) begin
        s1 <= rst ? 3'b000 : raw;
        s2 <= rst ? 3'b000 : s1;
    end

    // ev fires on the same edge db rises, so it is a one-cycle press strobe
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                db[i]   <= 1'b0;
                ev[i]   <= 1'b0;
                dcnt[i] <= '0;
            end else begin
                ev[i]   <= s2[i] && !db[i] && dcnt[i] == DB_LAST;
                db[i]   <= (s2[i] != db[i] && dcnt[i] == DB_LAST) ? s2[i] : db[i];
                dcnt[i] <= (s2[i] == db[i] || dcnt[i] == DB_LAST) ? '0 : dcnt[i] + 1'b1;
            end
        end
    end

    assign cmd_sel = ev[2] ? 3'b100 : ev[1] ? 3'b010 : ev[0] ? 3'b001 : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cmd   <= 3'b000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cmd   <= cmd_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
        cmd_n   = cmd;
        if (state == IDLE && ev != 3'b000) begin
            state_n = PULSE;
            cnt_n   = PULSE_LOAD;
            cmd_n   = cmd_sel;
        end else if (state == PULSE && cnt == '0) begin
            state_n = LOCKOUT_CYCLES == 0 ? IDLE : LOCKOUT;
            cnt_n   = LOCK_LOAD;
        end else if (state == LOCKOUT && cnt == '0) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        out_n  = state == PULSE ? cmd : 3'b000;
        busy_n = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {put, right, left} <= 3'b000;
            busy               <= 1'b0;
        end else begin
            {put, right, left} <= out_n;
            busy               <= busy_n;
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios push expected pulses into a queue;
// a negedge monitor pops and checks each pulse the DUT emits.
module tb_btn_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_put = 1'b0;
    logic left, right, put, busy;

    typedef struct {
        logic [2:0] cmd;
        int         start;
        int         len;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES(10),
        .LOCKOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_put(btn_put),
        .left(left),
        .right(right),
        .put(put),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [2:0] cmd, input int start, input int len);
        exp_t e;
        e.cmd = cmd;
        e.start = start;
        e.len = len;
        q.push_back(e);
    endtask

    // Monitor: checks one-hot outputs, then start cycle, command and length of every pulse
    logic [2:0] prev = 3'b000, cur;
    int         plen = 0, exp_len = 0;
    always @(negedge clk) begin
        exp_t e;
        cur = {put, right, left};
        chk("onehot", int'($countones(cur) <= 1), 1);
        if (prev == 3'b000 && cur != 3'b000) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", int'(cur), 0);
                exp_len = 0;
            end else begin
                e = q.pop_front();
                chk("pulse_cmd", int'(cur), int'(e.cmd));
                chk("pulse_start", cyc, e.start);
                exp_len = e.len;
            end
            plen = 1;
        end else if (cur != 3'b000) begin
            if (cur != prev) chk("pulse_stable", int'(cur), int'(prev));
            plen++;
        end else if (prev != 3'b000) begin
            chk("pulse_len", plen, exp_len);
        end
        prev = cur;
    end

    initial begin
        int e0;
        tick(3);
        chk("rst_outs", int'({left, right, put, busy}), 0);
        rst = 1'b0;
        tick(3);
        chk("idle_outs", int'({left, right, put, busy}), 0);

        // Clean put press, held long after the pulse
        e0 = cyc + 1;
        btn_put = 1'b1;
        expect_pulse(3'b100, e0 + 7, 10);
        for (int n = 1; n <= 50; n++) begin
            tick(1);
            chk("busy_window", int'(busy), int'(cyc >= e0 + 7 && cyc <= e0 + 36));
        end
        btn_put = 1'b0;
        tick(10);

        // Bouncing right button, then stable high from edge e0+20
        e0 = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            btn_right = ((i / 2) % 2) == 0;
            tick(1);
        end
        btn_right = 1'b1;
        expect_pulse(3'b010, e0 + 27, 10);
        tick(45);
        btn_right = 1'b0;
        tick(10);

        // Simultaneous press: put wins
        e0 = cyc + 1;
        {btn_left, btn_right, btn_put} = 3'b111;
        expect_pulse(3'b100, e0 + 7, 10);
        tick(45);
        {btn_left, btn_right, btn_put} = 3'b000;
        tick(10);

        // Right press during lockout is discarded
        e0 = cyc + 1;
        btn_left = 1'b1;
        expect_pulse(3'b001, e0 + 7, 10);
        tick(8);
        btn_left = 1'b0;
        tick(14);
        btn_right = 1'b1;
        tick(10);
        btn_right = 1'b0;
        tick(30);

        // Reset on the third cycle of a put pulse
        e0 = cyc + 1;
        btn_put = 1'b1;
        expect_pulse(3'b100, e0 + 7, 2);
        tick(9);
        rst = 1'b1;
        btn_put = 1'b0;
        tick(1);
        chk("rst_mid_put", int'(put), 0);
        chk("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        tick(40);

        // Button held through a 2-cycle reset
        rst = 1'b1;
        btn_put = 1'b1;
        tick(2);
        rst = 1'b0;
        e0 = cyc + 1;
        expect_pulse(3'b100, e0 + 7, 10);
        tick(45);
        btn_put = 1'b0;
        tick(10);

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
